// File: rtl/dla_host_irq_demux.sv
// dla_host_irq_demux
//
// Sits between an AFU write master and downstream memory. It splits off
// "interrupt writes" and passes every other write through unchanged.
// An interrupt write is an AW whose s_awuser[UFLAG_BIT] is set.
// For an interrupt write:
//   - The AW is absorbed locally and sets the sticky irq_out bit selected by
//     s_awaddr[1:0].
//   - Its W beats are swallowed.
//   - An OKAY B response is produced locally.
//
// A small route FIFO records {is_irq, awid} for each accepted AW. W beats are
// steered using the FIFO head, and each entry is popped on the wlast handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*   AXI write channels from the source (AFU side)
//   m_aw*, m_w*, m_b*   AXI write channels toward downstream memory
//   irq_out[3:0]        sticky interrupt status, one bit per vector
//   irq_clear[3:0]      per-vector clear strobe (set wins over clear)
module dla_host_irq_demux #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 48,
  parameter int DATA_W      = 512,
  parameter int USER_W      = 8,
  parameter int UFLAG_BIT   = 0,
  parameter int ROUTE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  // AW from source
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [USER_W-1:0]   s_awuser,
  // W from source
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  // B to source
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  // AW to downstream
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  // W to downstream
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  // B from downstream
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  // Interrupt status
  output logic [3:0]          irq_out,
  input  logic [3:0]          irq_clear
);

  localparam int IDX_W = $clog2(ROUTE_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Route FIFO: the extra pointer MSB distinguishes full from empty.
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             route_irq [ROUTE_DEPTH];
  logic [ID_W-1:0]  route_id  [ROUTE_DEPTH];

  logic             full, empty;
  logic             head_irq;
  logic [ID_W-1:0]  head_id;

  logic             aw_flag;
  logic             aw_hs, w_hs, pop;
  logic [3:0]       irq_set;

  // Local B slot
  logic             lb_valid;
  logic [ID_W-1:0]  lb_id;

  // Only the flag bit of awuser steers anything; other bits are ignored.
  logic unused_awuser;
  assign unused_awuser = ^s_awuser;

  assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign head_irq = route_irq[rd_ptr[IDX_W-1:0]];
  assign head_id  = route_id[rd_ptr[IDX_W-1:0]];
  assign aw_flag  = s_awuser[UFLAG_BIT];

  // Payload fields are plain wires; only the handshakes are steered.
  assign m_awid   = s_awid;
  assign m_awaddr = s_awaddr;
  assign m_awlen  = s_awlen;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = s_wlast;

  // Handshake steering. Every handshake output is forced low while reset is
  // asserted, so nothing is accepted or offered during reset.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s_awready = 1'b0;
    m_awvalid = 1'b0;
    s_wready  = 1'b0;
    m_wvalid  = 1'b0;
    s_bvalid  = 1'b0;
    s_bid     = m_bid;
    s_bresp   = m_bresp;
    m_bready  = 1'b0;
    irq_set   = '0;

    if (!reset) begin
      // AW: an interrupt write needs only FIFO room. A normal write also
      // needs downstream ready.
      if (!full) begin
        s_awready = aw_flag ? 1'b1 : m_awready;
        m_awvalid = s_awvalid & ~aw_flag;
      end

      // W: steered by the route head. Stall while no AW is pending.
      if (!empty) begin
        if (head_irq) begin
          // The last beat waits until the local B slot is free.
          s_wready = s_wlast ? ~lb_valid : 1'b1;
        end else begin
          m_wvalid = s_wvalid;
          s_wready = m_wready;
        end
      end

      // B merge: the local slot has strict priority.
      s_bvalid = lb_valid | m_bvalid;
      m_bready = s_bready & ~lb_valid;
      if (lb_valid) begin
        s_bid   = lb_id;
        s_bresp = 2'b00;
      end
    end

    if (s_awvalid && s_awready && aw_flag) irq_set[s_awaddr[1:0]] = 1'b1;
  end

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign pop   = w_hs & s_wlast;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lb_valid <= 1'b0;
      lb_id    <= '0;
      irq_out  <= '0;
    end else begin
      if (aw_hs) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;

      // Load and drain of the local B slot never overlap: the last
      // interrupt beat stalls while lb_valid is set.
      if (lb_valid && s_bready) lb_valid <= 1'b0;
      if (pop && head_irq) begin
        lb_valid <= 1'b1;
        lb_id    <= head_id;
      end

      // Set wins over clear.
      irq_out <= (irq_out & ~irq_clear) | irq_set;
    end
  end

  // NOTE: the route storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      route_irq[wr_ptr[IDX_W-1:0]] <= aw_flag;
      route_id[wr_ptr[IDX_W-1:0]]  <= s_awid;
    end
  end

endmodule

// File: tb/tb_dla_host_irq_demux.sv
// Directed testbench for dla_host_irq_demux (default parameters).
module tb_dla_host_irq_demux;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 48;
  localparam int DATA_W = 512;
  localparam int USER_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                s_awvalid, s_awready;
  logic [ID_W-1:0]     s_awid;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [7:0]          s_awlen;
  logic [USER_W-1:0]   s_awuser;
  logic                s_wvalid, s_wready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wlast;
  logic                s_bvalid, s_bready;
  logic [ID_W-1:0]     s_bid;
  logic [1:0]          s_bresp;
  logic                m_awvalid, m_awready;
  logic [ID_W-1:0]     m_awid;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic                m_wvalid, m_wready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_bvalid, m_bready;
  logic [ID_W-1:0]     m_bid;
  logic [1:0]          m_bresp;
  logic [3:0]          irq_out;
  logic [3:0]          irq_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dla_host_irq_demux dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awuser(s_awuser),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .irq_out(irq_out), .irq_clear(irq_clear)
  );

  // Advance one clock and land 1 ns after the edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (still far from the edge).
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    s_awvalid = 1'b0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awuser = '0;
    s_wvalid  = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
    s_bready  = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid  = 1'b0; m_bid = '0; m_bresp = '0;
    irq_clear = '0;
  endtask

  task automatic drive_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len, input logic flag);
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len;
    s_awuser  = {7'd0, flag};
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    // Every handshake input is active: outputs must still be held low.
    drive_aw(4'd1, 48'h0, 8'd0, 1'b0);
    s_wvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1; s_bready = 1'b1; m_bvalid = 1'b1;
    tick(); tick(); settle();
    checks++; if ({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready} !== 6'b0) begin
      errors++; $display("FAIL reset_valids: got %b exp 000000",
                         {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}); end
    checks++; if (irq_out !== 4'b0000) begin
      errors++; $display("FAIL reset_irq: got %b exp 0000", irq_out); end
    reset = 1'b0;
    idle_inputs();
    s_wvalid = 1'b1; m_wready = 1'b1;
    tick(); settle();
    checks++; if ({s_wready, m_wvalid, s_bvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_empty_w: got %b exp 000", {s_wready, m_wvalid, s_bvalid}); end
    idle_inputs();
  endtask

  task automatic test_irq_write();
    drive_aw(4'd5, 48'h2, 8'd0, 1'b1);
    settle();
    checks++; if ({s_awready, m_awvalid} !== 2'b10) begin
      errors++; $display("FAIL irq_aw_hs: got %b exp 10", {s_awready, m_awvalid}); end
    checks++; if (irq_out !== 4'b0000) begin
      errors++; $display("FAIL irq_no_comb: got %b exp 0000", irq_out); end
    tick();
    idle_inputs();
    settle();
    checks++; if (irq_out !== 4'b0100) begin
      errors++; $display("FAIL irq_set_v2: got %b exp 0100", irq_out); end
    s_wvalid = 1'b1; s_wlast = 1'b1; s_wdata = {16{32'hDEAD_BEEF}}; s_wstrb = '1;
    m_wready = 1'b1; s_bready = 1'b1;
    settle();
    checks++; if ({s_wready, m_wvalid, s_bvalid} !== 3'b100) begin
      errors++; $display("FAIL irq_w_local: got %b exp 100", {s_wready, m_wvalid, s_bvalid}); end
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    settle();
    checks++; if ({s_bvalid, s_bid, s_bresp} !== {1'b1, 4'd5, 2'b00}) begin
      errors++; $display("FAIL irq_local_b: got v=%b id=%0d resp=%0d exp v=1 id=5 resp=0",
                         s_bvalid, s_bid, s_bresp); end
    tick(); settle();
    checks++; if (s_bvalid !== 1'b0) begin
      errors++; $display("FAIL irq_b_drain: got %b exp 0", s_bvalid); end
    irq_clear = 4'b0100;
    tick();
    irq_clear = 4'b0000;
    settle();
    checks++; if (irq_out !== 4'b0000) begin
      errors++; $display("FAIL irq_clear_v2: got %b exp 0000", irq_out); end
    idle_inputs();
  endtask

  task automatic test_normal();
    logic [DATA_W-1:0] exp_data;
    drive_aw(4'd3, 48'h0000_1234_5000, 8'd3, 1'b0);
    m_awready = 1'b1;
    settle();
    checks++; if ({m_awvalid, s_awready, m_awid, m_awlen, m_awaddr} !==
                  {1'b1, 1'b1, 4'd3, 8'd3, 48'h0000_1234_5000}) begin
      errors++; $display("FAIL norm_aw: got v=%b r=%b id=%0d len=%0d addr=%h exp v=1 r=1 id=3 len=3 addr=000012345000",
                         m_awvalid, s_awready, m_awid, m_awlen, m_awaddr); end
    tick();
    idle_inputs();
    m_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_data = {16{32'hA000_0000 + 32'(i)}};
      s_wvalid = 1'b1; s_wdata = exp_data; s_wstrb = {16{4'(i + 1)}};
      s_wlast  = (i == 3);
      settle();
      checks++; if ({m_wvalid, s_wready, m_wlast} !== {1'b1, 1'b1, (i == 3)} ||
                    m_wdata !== exp_data || m_wstrb !== {16{4'(i + 1)}}) begin
        errors++; $display("FAIL norm_w_beat%0d: got v=%b r=%b last=%b strb=%h data=%h", i,
                           m_wvalid, s_wready, m_wlast, m_wstrb, m_wdata[31:0]); end
      tick();
    end
    idle_inputs();
    m_bvalid = 1'b1; m_bid = 4'd3; m_bresp = 2'b01; s_bready = 1'b1;
    settle();
    checks++; if ({s_bvalid, s_bid, s_bresp, m_bready} !== {1'b1, 4'd3, 2'b01, 1'b1}) begin
      errors++; $display("FAIL norm_b: got v=%b id=%0d resp=%0d mr=%b exp v=1 id=3 resp=1 mr=1",
                         s_bvalid, s_bid, s_bresp, m_bready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_interleave();
    m_awready = 1'b1;
    drive_aw(4'd1, 48'h100, 8'd1, 1'b0);
    tick();
    drive_aw(4'd7, 48'h0, 8'd0, 1'b1);
    tick();
    idle_inputs();
    settle();
    checks++; if (irq_out !== 4'b0001) begin
      errors++; $display("FAIL il_irq0: got %b exp 0001", irq_out); end
    m_wready = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b0;
    settle();
    checks++; if ({m_wvalid, s_wready} !== 2'b11) begin
      errors++; $display("FAIL il_beat1_fwd: got %b exp 11", {m_wvalid, s_wready}); end
    tick();
    s_wlast = 1'b1;
    settle();
    checks++; if ({m_wvalid, s_wready, m_wlast} !== 3'b111) begin
      errors++; $display("FAIL il_beat2_fwd: got %b exp 111", {m_wvalid, s_wready, m_wlast}); end
    tick();
    settle();
    checks++; if ({m_wvalid, s_wready} !== 2'b01) begin
      errors++; $display("FAIL il_beat3_local: got %b exp 01", {m_wvalid, s_wready}); end
    tick();
    idle_inputs();
    s_bready = 1'b1;
    settle();
    checks++; if ({s_bvalid, s_bid} !== {1'b1, 4'd7}) begin
      errors++; $display("FAIL il_local_b: got v=%b id=%0d exp v=1 id=7", s_bvalid, s_bid); end
    tick();
    m_bvalid = 1'b1; m_bid = 4'd1; m_bresp = 2'b00;
    settle();
    checks++; if ({s_bvalid, s_bid, m_bready} !== {1'b1, 4'd1, 1'b1}) begin
      errors++; $display("FAIL il_down_b: got v=%b id=%0d mr=%b exp v=1 id=1 mr=1",
                         s_bvalid, s_bid, m_bready); end
    tick();
    idle_inputs();
    irq_clear = 4'b0001;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    m_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_aw(4'(i), 48'h1000 + 48'(i), 8'd0, 1'b0);
      settle();
      checks++; if (s_awready !== 1'b1) begin
        errors++; $display("FAIL bp_aw%0d_accept: got %b exp 1", i, s_awready); end
      tick();
    end
    drive_aw(4'd4, 48'h1004, 8'd0, 1'b0);
    settle();
    checks++; if ({s_awready, m_awvalid} !== 2'b00) begin
      errors++; $display("FAIL bp_aw5_stall: got %b exp 00", {s_awready, m_awvalid}); end
    tick();
    // Pop in this cycle must not free the slot until the next one.
    s_wvalid = 1'b1; s_wlast = 1'b1; m_wready = 1'b1;
    settle();
    checks++; if ({s_awready, s_wready} !== 2'b01) begin
      errors++; $display("FAIL bp_pop_same_cycle: got %b exp 01", {s_awready, s_wready}); end
    tick();
    s_wvalid = 1'b0;
    settle();
    checks++; if ({s_awready, m_awvalid} !== 2'b11) begin
      errors++; $display("FAIL bp_aw5_after_pop: got %b exp 11", {s_awready, m_awvalid}); end
    tick();
    s_awvalid = 1'b0;
    s_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    settle();
    checks++; if ({s_wready, m_wvalid} !== 2'b00) begin
      errors++; $display("FAIL bp_drained: got %b exp 00", {s_wready, m_wvalid}); end
    idle_inputs();

    // Local B and downstream B competing in the same cycle.
    drive_aw(4'd9, 48'h3, 8'd0, 1'b1);
    tick();
    idle_inputs();
    s_wvalid = 1'b1; s_wlast = 1'b1;
    tick();
    idle_inputs();
    m_bvalid = 1'b1; m_bid = 4'd2; m_bresp = 2'b00; s_bready = 1'b1;
    settle();
    checks++; if ({s_bvalid, s_bid, m_bready} !== {1'b1, 4'd9, 1'b0}) begin
      errors++; $display("FAIL bp_b_local_first: got v=%b id=%0d mr=%b exp v=1 id=9 mr=0",
                         s_bvalid, s_bid, m_bready); end
    tick();
    settle();
    checks++; if ({s_bvalid, s_bid, m_bready} !== {1'b1, 4'd2, 1'b1}) begin
      errors++; $display("FAIL bp_b_down_second: got v=%b id=%0d mr=%b exp v=1 id=2 mr=1",
                         s_bvalid, s_bid, m_bready); end
    tick();
    idle_inputs();
    irq_clear = 4'b1000;
    tick();
    idle_inputs();
    settle();
    checks++; if (irq_out !== 4'b0000) begin
      errors++; $display("FAIL bp_irq_cleared: got %b exp 0000", irq_out); end
  endtask

  task automatic test_set_clear();
    drive_aw(4'd2, 48'h1, 8'd0, 1'b1);
    tick();
    idle_inputs();
    settle();
    checks++; if (irq_out !== 4'b0010) begin
      errors++; $display("FAIL sc_set_v1: got %b exp 0010", irq_out); end
    drive_aw(4'd3, 48'h1, 8'd0, 1'b1);
    irq_clear = 4'b0010;
    tick();
    idle_inputs();
    settle();
    checks++; if (irq_out !== 4'b0010) begin
      errors++; $display("FAIL sc_set_wins: got %b exp 0010", irq_out); end
    irq_clear = 4'b0010;
    tick();
    idle_inputs();
    settle();
    checks++; if (irq_out !== 4'b0000) begin
      errors++; $display("FAIL sc_clear_v1: got %b exp 0000", irq_out); end
    // Drain both interrupt writes; the second last beat waits for the B slot.
    s_wvalid = 1'b1; s_wlast = 1'b1; s_bready = 1'b1;
    tick();
    settle();
    checks++; if ({s_wready, s_bvalid, s_bid} !== {1'b0, 1'b1, 4'd2}) begin
      errors++; $display("FAIL sc_last_stall: got r=%b bv=%b id=%0d exp r=0 bv=1 id=2",
                         s_wready, s_bvalid, s_bid); end
    tick();
    settle();
    checks++; if (s_wready !== 1'b1) begin
      errors++; $display("FAIL sc_last_resume: got %b exp 1", s_wready); end
    tick();
    settle();
    checks++; if ({s_wready, s_bvalid, s_bid} !== {1'b0, 1'b1, 4'd3}) begin
      errors++; $display("FAIL sc_second_b: got r=%b bv=%b id=%0d exp r=0 bv=1 id=3",
                         s_wready, s_bvalid, s_bid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    m_awready = 1'b1;
    drive_aw(4'd6, 48'h2000, 8'd3, 1'b0);
    tick();
    idle_inputs();
    m_wready = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b0;
    tick(); tick();
    reset = 1'b1;
    m_awready = 1'b1; s_bready = 1'b1;
    tick();
    settle();
    checks++; if ({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready} !== 6'b0) begin
      errors++; $display("FAIL rmb_in_reset: got %b exp 000000",
                         {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready}); end
    tick();
    reset = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({s_wready, m_wvalid, s_bvalid, m_awvalid, irq_out} !== 8'b0) begin
        errors++; $display("FAIL rmb_after_reset%0d: got %b exp 00000000", i,
                           {s_wready, m_wvalid, s_bvalid, m_awvalid, irq_out}); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_irq_write();
    test_normal();
    test_interleave();
    test_back_to_back();
    test_set_clear();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
